// File: rtl/serial_text_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_text_loader_pkg
// Purpose  : Shared constants, state encodings and the ASCII-to-display-word
//            mapping used by the serial text loader and its UART receiver.
// Contents : PLAY_WORD, BLANK_WORD, ASCII_LF, ASCII_ESC, loader and receiver
//            state enums, map_byte() helper.
// Revision : 1.0  initial release
// ============================================================================
package serial_text_loader_pkg;

  localparam logic [6:0] PLAY_WORD  = 7'h7F;
  localparam logic [6:0] BLANK_WORD = 7'h40;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_ESC  = 8'h1B;

  // Loader FSM. ESC_WAIT is only reachable when raw-column mode is built in.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PAD      = 2'd1,
    ESC_WAIT = 2'd2
  } state_e;

  // UART receiver FSM.
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  typedef enum logic [1:0] {
    MAP_IGNORE = 2'd0,
    MAP_EMIT   = 2'd1,
    MAP_LF     = 2'd2
  } map_kind_e;

  typedef struct packed {
    map_kind_e  kind;
    logic [6:0] word;
  } map_t;

  // Classify a received byte and produce its display word.
  // 0x5F would naturally map to 7'h7F, which is the play word, so it is
  // forced to blank along with the other glyphs the font cannot show.
  function automatic map_t map_byte(input logic [7:0] b);
    map_t       m;
    logic [7:0] d;
    m.kind = MAP_IGNORE;
    m.word = PLAY_WORD;
    d      = 8'h00;
    if (b == ASCII_LF) begin
      m.kind = MAP_LF;
    end else if (b >= 8'h20 && b <= 8'h5E) begin
      d      = b - 8'h20;
      m.kind = MAP_EMIT;
      m.word = {1'b1, d[5:0]};
    end else if (b >= 8'h61 && b <= 8'h7A) begin
      d      = b - 8'h40;
      m.kind = MAP_EMIT;
      m.word = {1'b1, d[5:0]};
    end else if (b == 8'h5F || b == 8'h60 || (b >= 8'h7B && b <= 8'h7E)) begin
      m.kind = MAP_EMIT;
      m.word = BLANK_WORD;
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_text_loader_uart_rx_8n1.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_8n1
// Purpose  : 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling timer,
//            LSB-first shifter, stop-bit check.
// Ports    : clk, rst_n (async active-low), rx (async serial in),
//            byte_valid (1-cycle pulse), byte_data[7:0], frame_err (1-cycle).
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_8n1
  import serial_text_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_valid_q, byte_valid_d;
  logic            frame_err_q, frame_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      rx_state_q   <= rx_state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        // Edge rather than level, so a line held low after a bad stop bit
        // does not retrigger endlessly.
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          cnt_d      = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
          else                   bit_idx_d  = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d        = '0;
          byte_valid_d = rx_sync_q;
          frame_err_d  = !rx_sync_q;
          rx_state_d   = RX_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = shift_q;
  assign frame_err  = frame_err_q;

endmodule
`default_nettype wire

// File: rtl/serial_text_loader.sv
`default_nettype none
// ============================================================================
// Module   : serial_text_loader
// Purpose  : UART front end for the column-font text display. Maps received
//            ASCII to 7-bit display words, one cycle each, holding the play
//            word between words, and pads each line with blanks on LF so
//            messages land aligned in the WORD_COUNT-slot display ring.
// Ports    : clk, rst_n (async active-low), rx (serial in),
//            word_out[6:0] (display data), busy (padding in progress),
//            frame_err (1-cycle pulse on bad stop bit).
// Options  : LOADER_RAW_EN - when defined, ESC (0x1B) makes the next byte a
//            raw column word {1'b0, b[5:0]}.
// Revision : 1.0  initial release
// ============================================================================
module serial_text_loader
  import serial_text_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int WORD_COUNT   = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [6:0] word_out,
  output logic       busy,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(WORD_COUNT + 1);
  localparam logic [CNT_W-1:0] WC = CNT_W'(WORD_COUNT);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       rx_frame_err;

  uart_rx_8n1 #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (rx_frame_err)
  );

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  line_cnt_q, line_cnt_d;
  logic [6:0]        word_q, word_d;
  logic              hold_valid_q, hold_valid_d;
  logic [7:0]        hold_data_q, hold_data_d;

  logic              in_valid;
  logic [7:0]        in_data;
  logic [CNT_W-1:0]  cnt_inc;
  map_t              mapped;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      line_cnt_q   <= '0;
      word_q       <= PLAY_WORD;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      line_cnt_q   <= line_cnt_d;
      word_q       <= word_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
    end
  end

  // A byte parked during padding takes priority over the live receiver in
  // the first idle cycle; the two cannot coincide since a frame is far
  // longer than a pad run.
  assign in_valid = hold_valid_q | byte_valid;
  assign in_data  = hold_valid_q ? hold_data_q : byte_data;
  assign mapped   = map_byte(in_data);
  assign cnt_inc  = (line_cnt_q == WC) ? line_cnt_q : line_cnt_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    line_cnt_d   = line_cnt_q;
    word_d       = PLAY_WORD;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          hold_valid_d = 1'b0;
`ifdef LOADER_RAW_EN
          if (in_data == ASCII_ESC) begin
            state_d = ESC_WAIT;
          end else
`endif
          begin
            case (mapped.kind)
              MAP_EMIT: begin
                word_d     = mapped.word;
                line_cnt_d = cnt_inc;
              end
              MAP_LF: begin
                if (line_cnt_q == WC) begin
                  // Line already filled (or overflowed) the ring: no padding.
                  line_cnt_d = '0;
                end else begin
                  // First blank goes out immediately; PAD supplies the rest.
                  state_d    = PAD;
                  word_d     = BLANK_WORD;
                  line_cnt_d = cnt_inc;
                end
              end
              default: ;
            endcase
          end
        end
      end
      PAD: begin
        if (byte_valid) begin
          hold_valid_d = 1'b1;
          hold_data_d  = byte_data;
        end
        if (line_cnt_q == WC) begin
          state_d    = IDLE;
          line_cnt_d = '0;
        end else begin
          word_d     = BLANK_WORD;
          line_cnt_d = cnt_inc;
        end
      end
`ifdef LOADER_RAW_EN
      ESC_WAIT: begin
        if (rx_frame_err) begin
          state_d = IDLE;
        end else if (byte_valid) begin
          word_d     = {1'b0, byte_data[5:0]};
          line_cnt_d = cnt_inc;
          state_d    = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign word_out  = word_q;
  assign busy      = (state_q == PAD);
  assign frame_err = rx_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_serial_text_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_text_loader
// Purpose  : Self-checking bench for serial_text_loader: table of single-byte
//            mappings plus directed line, padding, frame-error and reset
//            sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_serial_text_loader;

  localparam int CPB = 16;
  localparam int WC  = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [6:0] word_out;
  logic       busy;
  logic       frame_err;

  always #5 clk = ~clk;

  serial_text_loader #(
    .CLKS_PER_BIT (CPB),
    .WORD_COUNT   (WC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .word_out  (word_out),
    .busy      (busy),
    .frame_err (frame_err)
  );

  typedef struct {
    logic [6:0] w;
    logic       b;
    int         cyc;
  } ev_t;

  typedef struct {
    logic [7:0] b;
    logic       emit;
    logic [6:0] w;
  } vec_t;

  ev_t ev_q[$];
  int  cyc = 0;
  int  fe_cnt = 0;
  int  illegal_cnt = 0;
  int  n_pass = 0;
  int  n_total = 0;

  // Record every cycle that is not plain idle (play word, not busy).
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst_n) begin
      if (word_out !== 7'h7F || busy !== 1'b0) begin
        ev_t e;
        e.w = word_out; e.b = busy; e.cyc = cyc;
        ev_q.push_back(e);
      end
      if (frame_err === 1'b1) fe_cnt = fe_cnt + 1;
`ifndef LOADER_RAW_EN
      if (word_out[6] !== 1'b1) illegal_cnt = illegal_cnt + 1;
`endif
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_total = n_total + 1;
    if (act == exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input int tail);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    rx = stop;
    repeat (CPB) @(posedge clk);
    rx = 1'b1;
    repeat (tail) @(posedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_byte(b, 1'b1, 3 * CPB);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    ev_q.delete();
    fe_cnt = 0;
  endtask

  // n contiguous blank cycles with busy high, starting at event index start.
  task automatic check_pad(input string name, input int start, input int n);
    int bad;
    bad = 0;
    for (int i = start; i < start + n; i++) begin
      if (i >= ev_q.size()) bad++;
      else if (ev_q[i].w !== 7'h40 || ev_q[i].b !== 1'b1) bad++;
      else if (i > start && ev_q[i].cyc != ev_q[i-1].cyc + 1) bad++;
    end
    check(name, bad, 0);
  endtask

  vec_t tab[14];

  initial begin
    int bad;
    int t;

    tab[0]  = '{8'h41, 1'b1, 7'h61};  // 'A'
    tab[1]  = '{8'h61, 1'b1, 7'h61};  // 'a' folds to 'A'
    tab[2]  = '{8'h5F, 1'b1, 7'h40};  // '_' is blank, not play
    tab[3]  = '{8'h20, 1'b1, 7'h40};  // space
    tab[4]  = '{8'h5E, 1'b1, 7'h7E};  // '^'
    tab[5]  = '{8'h60, 1'b1, 7'h40};  // '`'
    tab[6]  = '{8'h7A, 1'b1, 7'h7A};  // 'z'
    tab[7]  = '{8'h7B, 1'b1, 7'h40};  // '{'
    tab[8]  = '{8'h7E, 1'b1, 7'h40};  // '~'
    tab[9]  = '{8'h30, 1'b1, 7'h50};  // '0'
    tab[10] = '{8'h0D, 1'b0, 7'h7F};  // CR ignored
    tab[11] = '{8'h7F, 1'b0, 7'h7F};  // DEL ignored
    tab[12] = '{8'h80, 1'b0, 7'h7F};
    tab[13] = '{8'hC1, 1'b0, 7'h7F};

    // Reset held while rx toggles: outputs stay at reset values.
    rst_n = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      rx = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (word_out !== 7'h7F || busy !== 1'b0 || frame_err !== 1'b0) bad++;
    end
    check("reset_values", bad, 0);
    do_reset();

    // Single-byte mapping table.
    for (int i = 0; i < 14; i++) begin
      ev_q.delete();
      send(tab[i].b);
      check($sformatf("map_count_%02h", tab[i].b), ev_q.size(), tab[i].emit ? 1 : 0);
      if (tab[i].emit && ev_q.size() > 0)
        check($sformatf("map_word_%02h", tab[i].b),
              int'({ev_q[0].b, ev_q[0].w}), int'({1'b0, tab[i].w}));
    end

    // Short line "HI\n": two words then 18 blanks.
    do_reset();
    send(8'h48); send(8'h49); send(8'h0A);
    check("short_count", ev_q.size(), 20);
    if (ev_q.size() >= 2) begin
      check("short_H", int'({ev_q[0].b, ev_q[0].w}), 'h68);
      check("short_I", int'({ev_q[1].b, ev_q[1].w}), 'h69);
    end
    check_pad("short_pad", 2, 18);

    // 19 characters then LF: exactly one blank.
    do_reset();
    for (int k = 0; k < 19; k++) send(8'h58);
    send(8'h0A);
    check("len19_count", ev_q.size(), 20);
    check_pad("len19_pad", 19, 1);

    // Exactly 20 characters then LF: no padding.
    do_reset();
    for (int k = 0; k < 20; k++) send(8'h58);
    send(8'h0A);
    check("len20_count", ev_q.size(), 20);

    // 25 letters then LF: every letter, no padding; then empty line pads 20.
    do_reset();
    for (int k = 0; k < 25; k++) send(8'h41 + 8'(k));
    send(8'h0A);
    check("long_count", ev_q.size(), 25);
    bad = 0;
    for (int k = 0; k < 25 && k < ev_q.size(); k++)
      if (ev_q[k].w !== 7'(7'h61 + k) || ev_q[k].b !== 1'b0) bad++;
    check("long_words", bad, 0);
    ev_q.delete();
    send(8'h0A);
    check("empty_count", ev_q.size(), 20);
    check_pad("empty_pad", 0, 20);

    // Bad stop bit: one frame_err pulse, no word; next byte still decodes.
    do_reset();
    send_byte(8'h41, 1'b0, 3 * CPB);
    check("ferr_pulses", fe_cnt, 1);
    check("ferr_no_word", ev_q.size(), 0);
    send(8'h42);
    check("after_ferr_count", ev_q.size(), 1);
    if (ev_q.size() > 0) check("after_ferr_word", int'(ev_q[0].w), 'h62);

    // Short low glitch is rejected at the mid-start check.
    ev_q.delete();
    fe_cnt = 0;
    rx = 1'b0;
    repeat (3) @(posedge clk);
    rx = 1'b1;
    repeat (12 * CPB) @(posedge clk);
    check("glitch_no_word", ev_q.size(), 0);
    check("glitch_no_ferr", fe_cnt, 0);
    send(8'h43);
    check("after_glitch_word", ev_q.size() > 0 ? int'(ev_q[0].w) : -1, 'h63);

    // ESC then 0x15.
    do_reset();
    send(8'h1B); send(8'h15);
`ifdef LOADER_RAW_EN
    check("raw_count", ev_q.size(), 1);
    if (ev_q.size() > 0) check("raw_word", int'({ev_q[0].b, ev_q[0].w}), 'h15);
`else
    check("esc_ignored", ev_q.size(), 0);
`endif

    // Reset in the middle of padding: immediate return to idle, no resume.
    do_reset();
    send_byte(8'h0A, 1'b1, 0);
    t = 0;
    while (busy !== 1'b1 && t < 64) begin
      @(posedge clk);
      t++;
    end
    check("midpad_busy_seen", int'(busy), 1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midpad_reset_word", int'(word_out), 'h7F);
    check("midpad_reset_busy", int'(busy), 0);
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    ev_q.delete();
    repeat (40) @(posedge clk);
    check("midpad_no_resume", ev_q.size(), 0);

    check("illegal_words", illegal_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
